// File: rtl/bcd_rtc_pkg.sv
// ---------------------------------------------------------------------------
// bcd_rtc_pkg
// Shared types, constants and BCD helper functions for the BCD real-time
// clock (bcd_rtc_clock) and its digit-pair counter (bcd_mod_counter).
//   bcd8_t        : two packed BCD digits (tens in [7:4], ones in [3:0])
//   hh12_t        : 12-hour presentation of an hour {pm, hh}
//   bcd_is_valid  : both nibbles are decimal digits and value <= max
//   bcd_inc       : BCD increment without wrap (caller handles modulus)
//   to_12h        : 24 h BCD hour -> 12 h BCD hour + PM flag
//   from_12h      : 12 h BCD hour + PM flag -> 24 h BCD hour
// ---------------------------------------------------------------------------
package bcd_rtc_pkg;

   typedef logic [7:0] bcd8_t;

   typedef struct packed {
      logic  pm;
      bcd8_t hh;
   } hh12_t;

   localparam bcd8_t BCD_59 = 8'h59;
   localparam bcd8_t BCD_23 = 8'h23;
   localparam bcd8_t BCD_12 = 8'h12;

   // For well-formed BCD, a plain binary compare orders values correctly,
   // so the range test only makes sense after the nibble test.
   function automatic logic bcd_is_valid(input bcd8_t v, input bcd8_t max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   function automatic bcd8_t bcd_inc(input bcd8_t v);
      bcd8_t r;
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic hh12_t to_12h(input bcd8_t hh24);
      hh12_t r;
      r.pm = (hh24 >= BCD_12);
      if (hh24 == 8'h00) begin
         r.hh = BCD_12;
      end else if (hh24 <= BCD_12) begin
         r.hh = hh24;
      end else if (hh24[3:0] >= 4'd2) begin
         // 13..19, 22..23: subtract 12 without a ones borrow
         r.hh = {hh24[7:4] - 4'd1, hh24[3:0] - 4'd2};
      end else begin
         // 20..21: ones digit borrows from the tens digit
         r.hh = {hh24[7:4] - 4'd2, hh24[3:0] + 4'd8};
      end
      return r;
   endfunction

   function automatic bcd8_t from_12h(input bcd8_t hh12, input logic pm);
      bcd8_t      r;
      logic [3:0] ones;
      ones = hh12[3:0] + 4'd2;
      if (hh12 == BCD_12) begin
         // 12 AM is midnight, 12 PM is noon
         r = pm ? BCD_12 : 8'h00;
      end else if (!pm) begin
         r = hh12;
      end else if (ones > 4'd9) begin
         r = {hh12[7:4] + 4'd2, ones - 4'd10};
      end else begin
         r = {hh12[7:4] + 4'd1, ones};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_rtc_clock_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter counting 00..MAX_VAL and wrapping to 00.
//   clk      in   clock
//   reset    in   synchronous active-high reset (value -> RESET_VAL)
//   inc      in   advance by one this cycle
//   load     in   overwrite with load_val (wins over inc)
//   load_val in   BCD value to load
//   value    out  current BCD value
//   carry    out  inc while at MAX_VAL (value wraps on this edge)
// ---------------------------------------------------------------------------
module bcd_mod_counter
   import bcd_rtc_pkg::*;
#(
   parameter bcd8_t MAX_VAL   = BCD_59,
   parameter bcd8_t RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       carry
);

   bcd8_t value_reg;

   assign carry = inc && (value_reg == MAX_VAL);
   assign value = value_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         value_reg <= RESET_VAL;
      end else if (load) begin
         value_reg <= load_val;
      end else if (inc) begin
         value_reg <= carry ? 8'h00 : bcd_inc(value_reg);
      end
   end

endmodule

// File: rtl/bcd_rtc_clock.sv
// ---------------------------------------------------------------------------
// bcd_rtc_clock
// BCD real-time clock: keeps 24 h BCD time, presents it in 12 h or 24 h
// format, advances seconds from a programmable prescaler, and accepts a
// validated time-set load over a valid/ready handshake.
// Optional alarm: define BCD_RTC_ALARM_EN.
//   clk, reset               clock, synchronous active-high reset
//   ena                      prescaler count enable
//   mode24                   0 = 12 h presentation, 1 = 24 h
//   load_valid / load_ready  time-set handshake
//   load_hh/mm/ss, load_pm   BCD time to load (hh in mode24 format)
//   hh / mm / ss, pm         presented BCD time, PM indicator
//   tick                     registered pulse, cycle after ss advances
//   load_err                 pulse, cycle after an invalid load
//   alarm_wr, alarm_hh24, alarm_mm, alarm_on, alarm_fire  (alarm build)
// ---------------------------------------------------------------------------
module bcd_rtc_clock
   import bcd_rtc_pkg::*;
#(
   parameter int          TICK_DIV   = 1,
   parameter logic [7:0]  RESET_HH24 = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       mode24,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_hh,
   input  logic [7:0] load_mm,
   input  logic [7:0] load_ss,
   input  logic       load_pm,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       pm,
   output logic       tick,
`ifdef BCD_RTC_ALARM_EN
   input  logic       alarm_wr,
   input  logic [7:0] alarm_hh24,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_on,
   output logic       alarm_fire,
`endif
   output logic       load_err
);

   localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] p_reg;
   logic          ready_reg;
   logic          tick_reg;
   logic          err_reg;

   logic          tick_now;
   logic          tick_adv;
   logic          load_acc;
   logic          load_fields_ok;
   logic          load_ok;
   logic          hh_ok;
   bcd8_t         hh24_load;
   hh12_t         h12;

   bcd8_t         cnt_val      [3];
   bcd8_t         cnt_load_val [3];
   logic [2:0]    cnt_inc;
   logic [2:0]    cnt_carry;
   logic          hh_carry_unused;

   // ---------------- load validation and conversion ----------------
   assign hh_ok = mode24 ? bcd_is_valid(load_hh, BCD_23)
                         : (bcd_is_valid(load_hh, BCD_12) && (load_hh != 8'h00));

   assign load_fields_ok = hh_ok
                         && bcd_is_valid(load_mm, BCD_59)
                         && bcd_is_valid(load_ss, BCD_59);

   assign hh24_load = mode24 ? load_hh : from_12h(load_hh, load_pm);

   assign load_acc = load_valid && ready_reg;
   assign load_ok  = load_acc && load_fields_ok;

   // A valid load restarts the second, so it also swallows a coincident tick.
   assign tick_now = ena && (p_reg == P_LAST);
   assign tick_adv = tick_now && !load_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         p_reg     <= '0;
         ready_reg <= 1'b0;
         tick_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         ready_reg <= 1'b1;
         tick_reg  <= tick_adv;
         err_reg   <= load_acc && !load_fields_ok;
         if (load_ok) begin
            p_reg <= '0;
         end else if (ena) begin
            p_reg <= (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
         end
      end
   end

   // ---------------- ss / mm / hh24 counter chain ----------------
   assign cnt_load_val[0] = load_ss;
   assign cnt_load_val[1] = load_mm;
   assign cnt_load_val[2] = hh24_load;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cnt
         if (gi == 0) begin : g_first
            assign cnt_inc[gi] = tick_adv;
         end else begin : g_chain
            assign cnt_inc[gi] = cnt_carry[gi-1];
         end

         bcd_mod_counter #(
            .MAX_VAL   ((gi == 2) ? BCD_23     : BCD_59),
            .RESET_VAL ((gi == 2) ? RESET_HH24 : 8'h00)
         ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (cnt_inc[gi]),
            .load     (load_ok),
            .load_val (cnt_load_val[gi]),
            .value    (cnt_val[gi]),
            .carry    (cnt_carry[gi])
         );
      end
   endgenerate

   // Day rollover is not reported anywhere.
   assign hh_carry_unused = cnt_carry[2];

   // ---------------- presentation ----------------
   assign h12        = to_12h(cnt_val[2]);
   assign hh         = mode24 ? cnt_val[2] : h12.hh;
   assign pm         = h12.pm;
   assign mm         = cnt_val[1];
   assign ss         = cnt_val[0];
   assign tick       = tick_reg;
   assign load_err   = err_reg;
   assign load_ready = ready_reg;

`ifdef BCD_RTC_ALARM_EN
   // ---------------- alarm ----------------
   bcd8_t alarm_hh_reg;
   bcd8_t alarm_mm_reg;
   logic  alarm_armed_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         alarm_hh_reg    <= 8'h00;
         alarm_mm_reg    <= 8'h00;
         alarm_armed_reg <= 1'b0;
      end else if (alarm_wr) begin
         alarm_hh_reg    <= alarm_hh24;
         alarm_mm_reg    <= alarm_mm;
         alarm_armed_reg <= alarm_on;
      end
   end

   // Qualified by tick_reg, which is never set after a load, so loading the
   // alarm time directly cannot fire.
   assign alarm_fire = tick_reg && alarm_armed_reg
                    && (cnt_val[0] == 8'h00)
                    && (cnt_val[1] == alarm_mm_reg)
                    && (cnt_val[2] == alarm_hh_reg);
`endif

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// ---------------------------------------------------------------------------
// tb_bcd_rtc_clock
// Self-checking bench for bcd_rtc_clock (TICK_DIV = 4). Every clock cycle a
// seconds-of-day reference model predicts the outputs; the prediction is
// queued before the edge and popped/compared after it. A table of load
// vectors and hand-written sequences add constant expectations.
// ---------------------------------------------------------------------------
module tb_bcd_rtc_clock;

   localparam int TICK_DIV = 4;
   localparam int RST_SECS = 0;

   logic       clk;
   logic       reset;
   logic       ena;
   logic       mode24;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_hh;
   logic [7:0] load_mm;
   logic [7:0] load_ss;
   logic       load_pm;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       pm;
   logic       tick;
   logic       load_err;
`ifdef BCD_RTC_ALARM_EN
   logic       alarm_wr;
   logic [7:0] alarm_hh24;
   logic [7:0] alarm_mm;
   logic       alarm_on;
   logic       alarm_fire;
`endif

   bcd_rtc_clock #(
      .TICK_DIV   (TICK_DIV),
      .RESET_HH24 (8'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ena        (ena),
      .mode24     (mode24),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_hh    (load_hh),
      .load_mm    (load_mm),
      .load_ss    (load_ss),
      .load_pm    (load_pm),
      .hh         (hh),
      .mm         (mm),
      .ss         (ss),
      .pm         (pm),
      .tick       (tick),
`ifdef BCD_RTC_ALARM_EN
      .alarm_wr   (alarm_wr),
      .alarm_hh24 (alarm_hh24),
      .alarm_mm   (alarm_mm),
      .alarm_on   (alarm_on),
      .alarm_fire (alarm_fire),
`endif
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       tick;
      logic       err;
      logic       ready;
      logic       pm;
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
   } obs_t;

   obs_t sb_q[$];

   int m_secs  = 0;
   int m_p     = 0;
   bit m_ready = 0;
   bit m_tick  = 0;
   bit m_err   = 0;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic int from_bcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit load_is_valid(input logic [7:0] h, input logic [7:0] m,
                                        input logic [7:0] s, input bit m24);
      int hv;
      if (h[7:4] > 4'd9 || h[3:0] > 4'd9) return 1'b0;
      if (m[7:4] > 4'd9 || m[3:0] > 4'd9) return 1'b0;
      if (s[7:4] > 4'd9 || s[3:0] > 4'd9) return 1'b0;
      if (from_bcd(m) > 59 || from_bcd(s) > 59) return 1'b0;
      hv = from_bcd(h);
      if (m24) return (hv <= 23);
      return (hv >= 1) && (hv <= 12);
   endfunction

   function automatic int load_secs(input logic [7:0] h, input logic [7:0] m,
                                    input logic [7:0] s, input bit m24, input bit p);
      int hv;
      int h24;
      hv = from_bcd(h);
      if (m24)          h24 = hv;
      else if (hv == 12) h24 = p ? 12 : 0;
      else              h24 = p ? hv + 12 : hv;
      return h24 * 3600 + from_bcd(m) * 60 + from_bcd(s);
   endfunction

   function automatic obs_t present(input int secs, input bit m24);
      obs_t o;
      int   h24;
      int   hd;
      h24 = secs / 3600;
      if (m24)          hd = h24;
      else if (h24 == 0) hd = 12;
      else if (h24 > 12) hd = h24 - 12;
      else              hd = h24;
      o.tick  = m_tick;
      o.err   = m_err;
      o.ready = m_ready;
      o.pm    = (h24 >= 12);
      o.hh    = to_bcd(hd);
      o.mm    = to_bcd((secs / 60) % 60);
      o.ss    = to_bcd(secs % 60);
      return o;
   endfunction

   task automatic model_step();
      bit acc;
      bit ok;
      if (reset) begin
         m_secs = RST_SECS; m_p = 0; m_tick = 0; m_err = 0; m_ready = 0;
      end else begin
         acc     = load_valid && m_ready;
         ok      = acc && load_is_valid(load_hh, load_mm, load_ss, mode24);
         m_ready = 1;
         if (ok) begin
            m_secs = load_secs(load_hh, load_mm, load_ss, mode24, load_pm);
            m_p    = 0;
            m_tick = 0;
            m_err  = 0;
         end else begin
            m_err  = acc;
            m_tick = ena && (m_p == TICK_DIV - 1);
            if (ena) m_p = (m_p + 1) % TICK_DIV;
            if (m_tick) m_secs = (m_secs + 1) % 86400;
         end
      end
   endtask

   // One clock: predict, push, let the edge happen, pop and compare.
   task automatic cycle();
      obs_t exp_o;
      obs_t act_o;
      model_step();
      sb_q.push_back(present(m_secs, mode24));
      @(posedge clk);
      #1;
      exp_o = sb_q.pop_front();
      act_o = '{tick: tick, err: load_err, ready: load_ready, pm: pm, hh: hh, mm: mm, ss: ss};
      check("scoreboard", 32'(act_o), 32'(exp_o));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_load(input bit m24, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input bit p);
      mode24 = m24; load_hh = h; load_mm = m; load_ss = s; load_pm = p;
      load_valid = 1'b1;
      cycle();
      load_valid = 1'b0;
   endtask

   // ---------------- load vector table ----------------
   typedef struct {
      bit         m24;
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
      bit         pm;
      bit         err;
      logic [7:0] e_hh;
      logic [7:0] e_mm;
      logic [7:0] e_ss;
      bit         e_pm;
   } load_vec_t;

   load_vec_t vecs [13];

   initial begin
      vecs[0]  = '{0, 8'h11, 8'h59, 8'h58, 1, 0, 8'h11, 8'h59, 8'h58, 1};
      vecs[1]  = '{1, 8'h12, 8'h59, 8'h59, 0, 0, 8'h12, 8'h59, 8'h59, 1};
      vecs[2]  = '{1, 8'h23, 8'h59, 8'h59, 0, 0, 8'h23, 8'h59, 8'h59, 1};
      vecs[3]  = '{0, 8'h12, 8'h00, 8'h00, 0, 0, 8'h12, 8'h00, 8'h00, 0};
      vecs[4]  = '{0, 8'h12, 8'h30, 8'h00, 1, 0, 8'h12, 8'h30, 8'h00, 1};
      vecs[5]  = '{0, 8'h07, 8'h05, 8'h09, 1, 0, 8'h07, 8'h05, 8'h09, 1};
      vecs[6]  = '{1, 8'h1A, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0};
      vecs[7]  = '{1, 8'h00, 8'h60, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0};
      vecs[8]  = '{0, 8'h00, 8'h10, 8'h10, 0, 1, 8'h00, 8'h00, 8'h00, 0};
      vecs[9]  = '{1, 8'h24, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0};
      vecs[10] = '{1, 8'h10, 8'h10, 8'h5A, 0, 1, 8'h00, 8'h00, 8'h00, 0};
      vecs[11] = '{0, 8'h13, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 0};
      vecs[12] = '{1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0};
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; ena = 1'b0; mode24 = 1'b0; load_valid = 1'b0;
      load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00; load_pm = 1'b0;
`ifdef BCD_RTC_ALARM_EN
      alarm_wr = 1'b0; alarm_hh24 = 8'h00; alarm_mm = 8'h00; alarm_on = 1'b0;
`endif
      #2;

      // Reset state
      run(2);
      check("reset_hh12", 32'(hh), 32'h12);
      check("reset_mm", 32'(mm), 32'h00);
      check("reset_ss", 32'(ss), 32'h00);
      check("reset_pm", 32'(pm), 32'h0);
      check("reset_ready", 32'(load_ready), 32'h0);
      mode24 = 1'b1;
      #1;
      check("reset_hh24", 32'(hh), 32'h00);
      mode24 = 1'b0;
      $display("reset: %h:%h:%h pm=%0b", hh, mm, ss, pm);

      // Prescaler: ena high, tick on every 4th cycle
      reset = 1'b0; ena = 1'b1;
      run(3);
      check("no_tick_early", 32'(tick), 32'h0);
      run(1);
      check("first_tick", 32'(tick), 32'h1);
      check("first_ss", 32'(ss), 32'h01);
      run(4);
      check("second_tick", 32'(tick), 32'h1);
      $display("prescaler: ss=%h tick=%0b", ss, tick);

      // ena low for 3 cycles mid-count: tick arrives 3 cycles late
      run(2);
      ena = 1'b0;
      run(3);
      ena = 1'b1;
      run(1);
      check("paused_no_tick", 32'(tick), 32'h0);
      run(1);
      check("paused_tick", 32'(tick), 32'h1);
      check("paused_ss", 32'(ss), 32'h03);
      $display("pause: ss=%h tick=%0b", ss, tick);

      // 11:59:58 PM in 12 h mode, two ticks -> 12:00:00 AM
      do_load(1'b0, 8'h11, 8'h59, 8'h58, 1'b1);
      check("load_no_tick", 32'(tick), 32'h0);
      run(8);
      check("midnight_hh", 32'(hh), 32'h12);
      check("midnight_mmss", 32'({mm, ss}), 32'h0000);
      check("midnight_pm", 32'(pm), 32'h0);
      mode24 = 1'b1;
      #1;
      check("midnight_hh24", 32'(hh), 32'h00);
      check("midnight_ss_kept", 32'(ss), 32'h00);
      run(1);
      $display("midnight: %h:%h:%h pm=%0b mode24=1", hh, mm, ss, pm);

      // 12:59:59 in 24 h mode, one tick -> 13:00:00 / 01:00:00 PM
      do_load(1'b1, 8'h12, 8'h59, 8'h59, 1'b0);
      run(4);
      check("pm_roll_hh24", 32'(hh), 32'h13);
      check("pm_roll_mmss", 32'({mm, ss}), 32'h0000);
      mode24 = 1'b0;
      #1;
      check("pm_roll_hh12", 32'(hh), 32'h01);
      check("pm_roll_pm", 32'(pm), 32'h1);
      $display("pm roll: %h:%h:%h pm=%0b", hh, mm, ss, pm);

      // Table of back-to-back loads (valid and invalid)
      for (int i = 0; i < 13; i++) begin
         mode24 = vecs[i].m24; load_hh = vecs[i].hh; load_mm = vecs[i].mm;
         load_ss = vecs[i].ss; load_pm = vecs[i].pm; load_valid = 1'b1;
         cycle();
         check($sformatf("vec%0d_err", i), 32'(load_err), 32'(vecs[i].err));
         if (!vecs[i].err) begin
            check($sformatf("vec%0d_time", i), {7'd0, pm, hh, mm, ss},
                  {7'd0, vecs[i].e_pm, vecs[i].e_hh, vecs[i].e_mm, vecs[i].e_ss});
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'h0);
         end
         $display("load %0d: in=%h:%h:%h pm=%0b m24=%0b -> %h:%h:%h pm=%0b err=%0b",
                  i, vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].pm, vecs[i].m24,
                  hh, mm, ss, pm, load_err);
      end
      load_valid = 1'b0;

      // Invalid loads leave time running
      do_load(1'b1, 8'h05, 8'h06, 8'h07, 1'b0);
      do_load(1'b1, 8'h1A, 8'h00, 8'h00, 1'b0);
      check("inv_hh_err", 32'(load_err), 32'h1);
      check("inv_hh_time", 32'({hh, mm, ss}), 32'h050607);
      do_load(1'b1, 8'h00, 8'h60, 8'h00, 1'b0);
      do_load(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      check("inv_12h00_err", 32'(load_err), 32'h1);
      run(1);
      check("err_one_cycle", 32'(load_err), 32'h0);
      check("inv_ticked", 32'({mm, ss}), 32'h0608);
      $display("invalid loads: %h:%h:%h", hh, mm, ss);

      // Reset in the middle of a load discards it
      reset = 1'b1;
      do_load(1'b1, 8'h05, 8'h05, 8'h05, 1'b0);
      check("rst_load_time", 32'({hh, mm, ss}), 32'h000000);
      check("rst_load_ready", 32'(load_ready), 32'h0);
      reset = 1'b0;
      run(2);
      check("ready_after_rst", 32'(load_ready), 32'h1);
      $display("reset mid-load: %h:%h:%h ready=%0b", hh, mm, ss, load_ready);

`ifdef BCD_RTC_ALARM_EN
      // Alarm at 07:30 fires together with the tick that reaches 07:30:00
      alarm_wr = 1'b1; alarm_hh24 = 8'h07; alarm_mm = 8'h30; alarm_on = 1'b1;
      run(1);
      alarm_wr = 1'b0;
      do_load(1'b1, 8'h07, 8'h29, 8'h59, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         check($sformatf("alarm_fire_c%0d", k), 32'(alarm_fire), 32'(k == 4));
         check($sformatf("alarm_tick_c%0d", k), 32'(tick), 32'(k == 4));
      end
      $display("alarm: fired at 07:30:00, now %h:%h:%h", hh, mm, ss);
      do_load(1'b1, 8'h07, 8'h30, 8'h00, 1'b0);
      check("alarm_load_nofire", 32'(alarm_fire), 32'h0);
      for (int k = 1; k <= 5; k++) begin
         cycle();
         check($sformatf("alarm_quiet_c%0d", k), 32'(alarm_fire), 32'h0);
      end
      $display("alarm: direct load onto alarm time, now %h:%h:%h", hh, mm, ss);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_rtc_clock.md
# bcd_rtc_clock

Parametrised BCD real-time clock that succeeds the fixed 12-hour counter: it keeps time internally in 24-hour BCD, presents it in 12-hour or 24-hour format selected at run time, derives the seconds tick from a programmable prescaler, and accepts a validated time-set load through a valid/ready handshake. It sits under the traffic-light controller as its time-of-day source and drives the display and schedule logic.

## Interface
- TICK_DIV, 1: enabled clk cycles per seconds tick (≥1)
- RESET_HH24, 8'h00: hour loaded on reset, 24 h BCD (8'h00 = 12 AM)
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- ena  in  1  count enable; prescaler advances only when high
- mode24  in  1  0 = 12 h presentation, 1 = 24 h presentation
- load_valid  in  1  time-set request
- load_ready  out  1  block can accept a load this cycle
- load_hh / load_mm / load_ss  in  8 each  BCD time to load (hh in the format selected by mode24)
- load_pm  in  1  PM flag for a 12 h load; ignored when mode24 = 1
- hh / mm / ss  out  8 each  BCD time
- pm  out  1  PM indicator (hour ≥ 12 in either mode)
- tick  out  1  one-cycle pulse on the cycle the seconds value advances
- load_err  out  1  one-cycle pulse when an accepted load is rejected as invalid

## Operation
- State: ss, mm, hh24 (BCD), prescaler count p of width max(1, $clog2(TICK_DIV)).
- Reset: ss = 00, mm = 00, hh24 = RESET_HH24, p = 0, tick = 0, load_err = 0, load_ready = 0. Default outputs are 12:00:00, pm = 0.
- Prescaler: when ena = 1, p increments; at p = TICK_DIV−1, p wraps to 0 and a tick occurs. When ena = 0, p holds. TICK_DIV = 1 ticks on every enabled cycle.
- On a tick: ss advances in BCD 00→59. Wrap 59→00 carries into mm, which advances 00→59. Wrap carries into hh24, which advances 00→23. 23:59:59 → 00:00:00.
- Presentation is combinational from state and mode24:
  - 24 h: hh = hh24; pm = (hh24 ≥ 12).
  - 12 h: hh24 00 → 12, pm 0; 01–11 → same, pm 0; 12 → 12, pm 1; 13–23 → hh24−12, pm 1.
  - Toggling mode24 changes only the presentation, never the state.
- Load handshake:
  - load_ready = 1 in every cycle except the reset cycle.
  - A load is accepted when load_valid & load_ready.
  - Validity: every nibble ≤ 9; ss ≤ 59; mm ≤ 59; hh 00–23 (24 h) or 01–12 (12 h).
  - Valid load: on the next edge, the state takes the converted values (12 h: 12 AM → 00, 12 PM → 12, other PM → +12), p clears to 0, and no tick is issued in that cycle.
  - Invalid load: state and p are unchanged, the tick still proceeds normally, and load_err pulses in the following cycle.
- Priority, highest first: reset > accepted load > tick.

## Timing
- tick is registered: it is high in the cycle after the edge where ss updates. It is never high in the cycle after a valid load.
- Outputs reflect a new state the cycle after the edge, with zero added latency beyond the register.
- Loads complete in one cycle; load_valid may stay high back-to-back, and each cycle is a separate accepted load.
- Reset mid-load: the load is discarded.

## Configuration
- BCD_RTC_ALARM_EN defined:
  - Adds alarm_wr (in 1), alarm_hh24 (in 8), alarm_mm (in 8), alarm_on (in 1), and alarm_fire (out 1).
  - alarm_wr latches the alarm time and arm flag. Reset clears the arm flag.
  - alarm_fire pulses for one cycle, aligned with tick, when a tick produces hh24:mm:00 equal to the alarm and the alarm is armed.
  - A load onto the alarm time does not fire.
- Macro undefined: these ports and all alarm logic are absent.

## Structure
- Package bcd_rtc_pkg holds:
  - bcd8_t (8-bit BCD pair) typedef;
  - constants BCD_59, BCD_23, BCD_12;
  - functions bcd_is_valid, bcd_inc, to_12h, from_12h.
- Sub-module bcd_mod_counter, parameterised by BCD modulus, has inputs inc and load with load value, and outputs the value and carry. It is instantiated three times (ss, mm, hh24).

## Test plan
- Reset with default parameters → 12:00:00, pm 0 in 12 h mode and 00:00:00 in 24 h mode. After 1 s of ticks → ss = 01.
- TICK_DIV = 4, ena held high → tick every 4th cycle. ena low for 3 cycles mid-count → tick delayed by exactly 3 cycles.
- Load 11:59:58 PM (12 h), then 2 ticks → 12:00:00 AM, pm 0, hh24 = 00. Then switch mode24 = 1 → hh = 00 with no state change.
- Load 12:59:59 in 24 h mode, then 1 tick → 13:00:00 in 24 h mode, and 01:00:00 pm 1 in 12 h mode.
- Load hh = 8'h1A, then mm = 8'h60, then 12 h hh = 00 → load_err pulses each time, the time is unchanged, and ticks continue.
- With BCD_RTC_ALARM_EN: set alarm 07:30 armed, load 07:29:59, tick → alarm_fire high for one cycle together with tick. Directly loading 07:30:00 → no fire.
